// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the programmable-threshold synchronous FIFO.
// Contents:
//   fifo_depth(ptr_size)  : number of words for a given pointer width (1 << ptr_size)
//   level_width(ptr_size) : width of pointers, fill level and threshold ports (ptr_size + 1)
package sync_fifo_pkg;

  function automatic int unsigned fifo_depth(input int unsigned ptr_size);
    return 32'd1 << ptr_size;
  endfunction

  // One extra bit beyond the RAM address so that full and empty are distinguishable.
  function automatic int unsigned level_width(input int unsigned ptr_size);
    return ptr_size + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_memory.sv
// Simple dual-port RAM backing the FIFO.
// Synchronous write; registered read. A read and a write to the same address in the same
// cycle return the old contents. Only the read register is reset; the array is not cleared.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset (read register only)
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read strobe; rd_data holds its value while low
//   rd_addr  : read address
//   rd_data  : registered read data
module sync_fifo_memory
  import sync_fifo_pkg::*;
#(
  parameter int unsigned data_size = 8,
  parameter int unsigned addr_size = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  logic [addr_size-1:0] wr_addr,
  input  logic [data_size-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [addr_size-1:0] rd_addr,
  output logic [data_size-1:0] rd_data
);

  localparam int unsigned Depth = fifo_depth(addr_size);

  logic [data_size-1:0] mem [Depth];
  logic [data_size-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with runtime-programmable almost-full / almost-empty thresholds,
// registered fill level and sticky overflow / underflow flags.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through read mode;
// without it the FIFO has a one-cycle registered read latency.
// Ports:
//   clk, reset_n       : clock (rising edge) and asynchronous active-low reset
//   wr_valid, wr_data  : write request and data; ignored while full
//   rd_valid           : read request (standard) or pop acknowledge (FWFT)
//   af_thresh          : almost-full threshold, fifo_almost_full = level >= af_thresh
//   ae_thresh          : almost-empty threshold, fifo_almost_empty = level <= ae_thresh
//   err_clr            : clears sticky error flags (a concurrent new error wins)
//   rd_data            : read data
//   rd_data_valid      : standard: pulses with new rd_data; FWFT: !fifo_empty
//   fifo_full/empty    : status flags (registered)
//   fifo_almost_*      : threshold flags (registered)
//   fifo_level         : words stored, 0..DEPTH (registered)
//   fifo_overflow      : sticky, write attempted while full
//   fifo_underflow     : sticky, read attempted while empty
module sync_fifo_prog
  import sync_fifo_pkg::*;
#(
  parameter int unsigned fifo_data_size = 8,
  parameter int unsigned fifo_ptr_size  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_valid,
  input  logic [fifo_data_size-1:0] wr_data,
  input  logic                      rd_valid,
  input  logic [fifo_ptr_size:0]    af_thresh,
  input  logic [fifo_ptr_size:0]    ae_thresh,
  input  logic                      err_clr,
  output logic [fifo_data_size-1:0] rd_data,
  output logic                      rd_data_valid,
  output logic                      fifo_full,
  output logic                      fifo_empty,
  output logic                      fifo_almost_full,
  output logic                      fifo_almost_empty,
  output logic [fifo_ptr_size:0]    fifo_level,
  output logic                      fifo_overflow,
  output logic                      fifo_underflow
);

  localparam int unsigned LvlW = level_width(fifo_ptr_size);
  localparam logic [LvlW-1:0] DepthLvl = LvlW'(fifo_depth(fifo_ptr_size));

  logic [LvlW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LvlW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            full_q, empty_q, af_q, ae_q;
  logic            ovf_q, unf_q;
  logic            empty_d;
  logic            wr_accept, rd_accept;
  logic            ram_rd_en;
  logic [fifo_ptr_size-1:0] ram_rd_addr;

  // Acceptance uses the registered flags, so a same-cycle read never frees room for a write.
  always_comb begin
    wr_accept = wr_valid && !full_q;
    rd_accept = rd_valid && !empty_q;
    wr_ptr_d  = wr_ptr_q + LvlW'(wr_accept);
    rd_ptr_d  = rd_ptr_q + LvlW'(rd_accept);
    level_d   = wr_ptr_d - rd_ptr_d;
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic head_written;

  // The RAM always prefetches the next head. If this cycle's write lands on that head slot,
  // the prefetch returns stale data (no bypass), so hold empty for one more cycle.
  assign head_written  = wr_accept && (wr_ptr_q == rd_ptr_d);
  assign empty_d       = (level_d == '0) || head_written;
  assign ram_rd_en     = 1'b1;
  assign ram_rd_addr   = rd_ptr_d[fifo_ptr_size-1:0];
  assign rd_data_valid = !empty_q;
`else
  logic rd_data_valid_q;

  assign empty_d       = (level_d == '0);
  assign ram_rd_en     = rd_accept;
  assign ram_rd_addr   = rd_ptr_q[fifo_ptr_size-1:0];
  assign rd_data_valid = rd_data_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_valid_q <= 1'b0;
    end else begin
      rd_data_valid_q <= rd_accept;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == DepthLvl);
      empty_q  <= empty_d;
      af_q     <= (level_d >= af_thresh);
      ae_q     <= (level_d <= ae_thresh);
      // New error takes priority over a clear in the same cycle.
      ovf_q    <= (wr_valid && full_q) || (ovf_q && !err_clr);
      unf_q    <= (rd_valid && empty_q) || (unf_q && !err_clr);
    end
  end

  sync_fifo_memory #(
    .data_size (fifo_data_size),
    .addr_size (fifo_ptr_size)
  ) u_memory (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_q[fifo_ptr_size-1:0]),
    .wr_data (wr_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (rd_data)
  );

  assign fifo_full         = full_q;
  assign fifo_empty        = empty_q;
  assign fifo_almost_full  = af_q;
  assign fifo_almost_empty = ae_q;
  assign fifo_level        = level_q;
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog (16-deep, 8-bit). A queue-based reference model
// predicts every registered output after each clock edge; directed sequences cover reset,
// fill/drain, thresholds, simultaneous traffic, error flags and (when built with
// SYNC_FIFO_FWFT_EN) fall-through timing, followed by a randomized phase.
module tb_sync_fifo_prog;

  localparam int Depth = 16;

  logic       clk;
  logic       reset_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rd_data_valid;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_almost_full;
  logic       fifo_almost_empty;
  logic [4:0] fifo_level;
  logic       fifo_overflow;
  logic       fifo_underflow;

  sync_fifo_prog #(
    .fifo_data_size (8),
    .fifo_ptr_size  (4)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .wr_valid          (wr_valid),
    .wr_data           (wr_data),
    .rd_valid          (rd_valid),
    .af_thresh         (af_thresh),
    .ae_thresh         (ae_thresh),
    .err_clr           (err_clr),
    .rd_data           (rd_data),
    .rd_data_valid     (rd_data_valid),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_level        (fifo_level),
    .fifo_overflow     (fifo_overflow),
    .fifo_underflow    (fifo_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  data;
    logic [31:0] wcyc;
  } entry_t;

  entry_t     q[$];
  int         cyc = 0;
  logic       exp_full, exp_empty, exp_af, exp_ae, exp_ovf, exp_unf, exp_rdv;
  int         exp_level;
  logic [7:0] exp_rd_data;

  task automatic model_reset();
    q.delete();
    exp_full = 0; exp_empty = 1; exp_af = 0; exp_ae = 1;
    exp_ovf = 0; exp_unf = 0; exp_rdv = 0; exp_level = 0; exp_rd_data = 8'h00;
  endtask

  // Called right at a rising edge, with the inputs that were presented during the cycle.
  task automatic model_edge();
    bit     wacc, racc;
    entry_t e;
    wacc = wr_valid && !exp_full;
    racc = rd_valid && !exp_empty;
    exp_ovf = (wr_valid && exp_full) ? 1'b1 : (err_clr ? 1'b0 : exp_ovf);
    exp_unf = (rd_valid && exp_empty) ? 1'b1 : (err_clr ? 1'b0 : exp_unf);
    cyc++;
`ifndef SYNC_FIFO_FWFT_EN
    exp_rdv = racc;
    if (racc) exp_rd_data = q[0].data;
`endif
    if (racc) void'(q.pop_front());
    if (wacc) begin
      e.data = wr_data;
      e.wcyc = cyc;
      q.push_back(e);
    end
    exp_level = q.size();
    exp_full  = (q.size() == Depth);
    exp_af    = (q.size() >= int'(af_thresh));
    exp_ae    = (q.size() <= int'(ae_thresh));
`ifdef SYNC_FIFO_FWFT_EN
    // A head that was only just written is not yet readable.
    if (q.size() == 0) exp_empty = 1;
    else               exp_empty = (q[0].wcyc == cyc);
    exp_rdv = !exp_empty;
    if (!exp_empty) exp_rd_data = q[0].data;
`else
    exp_empty = (q.size() == 0);
`endif
  endtask

  task automatic check_outputs();
    check("level", fifo_level, exp_level);
    check("full", fifo_full, exp_full);
    check("empty", fifo_empty, exp_empty);
    check("almost_full", fifo_almost_full, exp_af);
    check("almost_empty", fifo_almost_empty, exp_ae);
    check("overflow", fifo_overflow, exp_ovf);
    check("underflow", fifo_underflow, exp_unf);
    check("rd_data_valid", rd_data_valid, exp_rdv);
`ifdef SYNC_FIFO_FWFT_EN
    if (!exp_empty) check("rd_data", rd_data, exp_rd_data);
`else
    check("rd_data", rd_data, exp_rd_data);
`endif
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_valid = w;
    wr_data  = d;
    rd_valid = r;
    err_clr  = c;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  // Asynchronous reset asserted between edges while inputs are still active.
  task automatic async_reset();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("rst_rd_data", rd_data, 8'h00);
    @(posedge clk);
    #1;
    check_outputs();
    check("rst_hold_rd_data", rd_data, 8'h00);
    @(negedge clk);
    wr_valid = 0; rd_valid = 0; err_clr = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_pct;
    reset_n = 0; wr_valid = 0; wr_data = 0; rd_valid = 0; err_clr = 0;
    af_thresh = 5'd12; ae_thresh = 5'd3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    check("init_empty", fifo_empty, 1'b1);
    check("init_level", fifo_level, 0);
    @(negedge clk);
    reset_n = 1;

    // Fill / drain with overflow and error clear
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    check("t2_full", fifo_full, 1'b1);
    check("t2_level", fifo_level, 16);
    step(1, 8'hEE, 0, 0);
    check("t2_overflow", fifo_overflow, 1'b1);
    check("t2_level_hold", fifo_level, 16);
    step(1, 8'hEF, 0, 1);
    check("t5_clr_vs_error", fifo_overflow, 1'b1);
    step(0, 8'h00, 0, 1);
    check("t5_clr", fifo_overflow, 1'b0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    check("t2_drained", fifo_empty, 1'b1);
    step(0, 8'h00, 1, 0);
    check("t2_underflow", fifo_underflow, 1'b1);
    step(0, 8'h00, 0, 1);
    check("t2_unf_clr", fifo_underflow, 1'b0);

    // Thresholds
    for (int i = 0; i < 11; i++) step(1, 8'($urandom), 0, 0);
    check("t3_af_below", fifo_almost_full, 1'b0);
    step(1, 8'($urandom), 0, 0);
    check("t3_af_rise", fifo_almost_full, 1'b1);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0);
    check("t3_ae_at4", fifo_almost_empty, 1'b0);
    step(0, 8'h00, 1, 0);
    check("t3_ae_at3", fifo_almost_empty, 1'b1);
    check("t3_level3", fifo_level, 3);

    // Simultaneous read/write at constant level (pointers wrap several times)
    step(1, 8'($urandom), 0, 0);
    step(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 100; i++) step(1, 8'($urandom), 1, 0);
    check("t4_level5", fifo_level, 5);

    // Reset in the middle of a write burst
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    wr_valid = 1;
    async_reset();

`ifdef SYNC_FIFO_FWFT_EN
    step(1, 8'hA5, 0, 0);
    check("t6_empty_bubble", fifo_empty, 1'b1);
    step(0, 8'h00, 0, 0);
    check("t6_empty_fall", fifo_empty, 1'b0);
    check("t6_head", rd_data, 8'hA5);
    for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1, 0);
      if (i < 4) check("t6_rate", rd_data, 8'(8'hB0 + i));
    end
    check("t6_drained", fifo_empty, 1'b1);
`endif

    // Randomized traffic with threshold changes and one reset
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        af_thresh = 5'($urandom_range(16));
        ae_thresh = 5'($urandom_range(16));
      end
      if (i == 300) begin
        wr_valid = 1; rd_valid = 1;
        async_reset();
      end
      wr_pct = ((i / 100) % 2 == 1) ? 75 : 30;
      step(1'($urandom_range(99) < wr_pct), 8'($urandom),
           1'($urandom_range(99) < 50), 1'($urandom_range(99) < 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
